// File: rtl/cpu_pkg.sv
// Shared constants and types for the processor front end.
// The fetch entry pairs an instruction word with the address it was fetched from.
package cpu_pkg;

  parameter int unsigned ADDR_W = 12;
  parameter int unsigned DATA_W = 32;
  parameter logic [ADDR_W-1:0] RESET_PC = 12'd0;

  typedef struct packed {
    logic [DATA_W-1:0] insn;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// 2-entry FIFO of {insn, pc} with flush; head outputs come straight from registers
// and read as zero whenever the queue is empty.
module fetch_queue
  import cpu_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_insn,
  input  logic [ADDR_W-1:0] push_pc,
  output logic              head_valid,
  output logic [DATA_W-1:0] head_insn,
  output logic [ADDR_W-1:0] head_pc,
  output logic [1:0]        count
);

  fetch_entry_t head_r, tail_r, head_s, tail_s, new_s;
  logic [1:0]   cnt_r, cnt_s;
  logic         valid_r, valid_s;

  // Next-state queue contents; the tail is kept zero whenever count < 2
  always_comb begin
    head_s  = head_r;
    tail_s  = tail_r;
    cnt_s   = cnt_r;
    new_s   = '{insn: push_insn, pc: push_pc};
    if (flush) begin
      head_s = '0;
      tail_s = '0;
      cnt_s  = 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_r == 2'd0) begin
            head_s = new_s;
          end else begin
            tail_s = new_s;
          end
          cnt_s = cnt_r + 2'd1;
        end
        2'b01: begin
          head_s = tail_r;
          tail_s = '0;
          cnt_s  = cnt_r - 2'd1;
        end
        2'b11: begin
          if (cnt_r == 2'd2) begin
            head_s = tail_r;
            tail_s = new_s;
          end else begin
            head_s = new_s;
          end
        end
        default: begin
          cnt_s = cnt_r;
        end
      endcase
    end
    valid_s = (cnt_s != 2'd0);
  end

  // Queue state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_r  <= '0;
      tail_r  <= '0;
      cnt_r   <= 2'd0;
      valid_r <= 1'b0;
    end else begin
      head_r  <= head_s;
      tail_r  <= tail_s;
      cnt_r   <= cnt_s;
      valid_r <= valid_s;
    end
  end

  assign head_valid = valid_r;
  assign head_insn  = head_r.insn;
  assign head_pc    = head_r.pc;
  assign count      = cnt_r;

  fetch_queue_chk u_chk (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .count (cnt_r)
  );

endmodule

// File: rtl/fetch_queue_chk.sv
// Assertion-only checker for the 2-entry fetch queue.
module fetch_queue_chk (
  input logic       clock,
  input logic       reset,
  input logic       push,
  input logic       pop,
  input logic       flush,
  input logic [1:0] count
);

  // Issue credits must never let an arrival land in a full queue
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
    (push && !pop && !flush) |-> (count != 2'd2));

  a_count_range: assert property (@(posedge clock) disable iff (!reset)
    count != 2'd3);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, tracks the one-cycle imem latency and
// only issues a fetch when the queue is guaranteed room for its return.
module fetch_unit
  import cpu_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] address_imem,
  input  logic [DATA_W-1:0] q_imem,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              insn_valid,
  input  logic              insn_ready,
  output logic [DATA_W-1:0] insn,
  output logic [ADDR_W-1:0] insn_pc
);

  logic [ADDR_W-1:0] pc_r, req_pc_r;
  logic              req_valid_r;
  logic [1:0]        q_count_s;
  logic              pop_s, arrive_s, issue_s;
  logic [2:0]        cnt_after_s;

  assign pop_s       = insn_valid & insn_ready;
  assign arrive_s    = req_valid_r;
  assign cnt_after_s = {1'b0, q_count_s} + {2'b00, arrive_s} - {2'b00, pop_s};
  assign issue_s     = (cnt_after_s <= 3'd1);

  // PC and in-flight request tracking; a redirect parks the PC on the target so
  // address_imem presents it for one cycle before it is issued
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_r        <= RESET_PC;
      req_valid_r <= 1'b0;
      req_pc_r    <= '0;
    end else if (redirect_valid) begin
      pc_r        <= redirect_target;
      req_valid_r <= 1'b0;
      req_pc_r    <= req_pc_r;
    end else if (issue_s) begin
      pc_r        <= pc_r + 12'd1;
      req_valid_r <= 1'b1;
      req_pc_r    <= pc_r;
    end else begin
      pc_r        <= pc_r;
      req_valid_r <= 1'b0;
      req_pc_r    <= req_pc_r;
    end
  end

  assign address_imem = pc_r;

  fetch_queue u_queue (
    .clock      (clock),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (arrive_s & ~redirect_valid),
    .pop        (pop_s & ~redirect_valid),
    .push_insn  (q_imem),
    .push_pc    (req_pc_r),
    .head_valid (insn_valid),
    .head_insn  (insn),
    .head_pc    (insn_pc),
    .count      (q_count_s)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit with a synchronous imem model
// returning 32'hA000_0000 + address.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] address_imem;
  logic [31:0] q_imem = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [11:0] redirect_target = 12'd0;
  logic        insn_valid;
  logic        insn_ready = 1'b0;
  logic [31:0] insn;
  logic [11:0] insn_pc;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit dut (
    .clock           (clock),
    .reset           (reset),
    .address_imem    (address_imem),
    .q_imem          (q_imem),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .insn_valid      (insn_valid),
    .insn_ready      (insn_ready),
    .insn            (insn),
    .insn_pc         (insn_pc)
  );

  always #5 clock = ~clock;

  always @(posedge clock) q_imem <= 32'hA000_0000 + {20'd0, address_imem};

  typedef struct {
    logic        ready;
    logic        rv;
    logic [11:0] rt;
    logic        v;
    logic [11:0] pc;
    logic [11:0] addr;
  } vec_t;

  vec_t tbl[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic v, input logic [11:0] pc,
                           input logic [11:0] addr);
    logic [31:0] exp_insn;
    exp_insn = v ? (32'hA000_0000 + {20'd0, pc}) : 32'd0;
    chk({name, ".valid"}, {31'd0, insn_valid}, {31'd0, v});
    chk({name, ".pc"}, {20'd0, insn_pc}, {20'd0, (v ? pc : 12'd0)});
    chk({name, ".insn"}, insn, exp_insn);
    chk({name, ".addr"}, {20'd0, address_imem}, {20'd0, addr});
  endtask

  task automatic step(input logic rdy, input logic rv, input logic [11:0] rt);
    insn_ready      = rdy;
    redirect_valid  = rv;
    redirect_target = rt;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // ready=1 stream, 5-cycle stall from pc 3, then redirect to 0x100 while full
    tbl[0]  = '{1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 12'h001};
    tbl[1]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h000, 12'h002};
    tbl[2]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h001, 12'h003};
    tbl[3]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h002, 12'h004};
    tbl[4]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h003, 12'h005};
    tbl[5]  = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h003, 12'h005};
    tbl[6]  = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h003, 12'h005};
    tbl[7]  = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h003, 12'h005};
    tbl[8]  = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h003, 12'h005};
    tbl[9]  = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h003, 12'h005};
    tbl[10] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h004, 12'h006};
    tbl[11] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h005, 12'h007};
    tbl[12] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h006, 12'h008};
    tbl[13] = '{1'b0, 1'b0, 12'h000, 1'b1, 12'h006, 12'h008};
    tbl[14] = '{1'b0, 1'b1, 12'h100, 1'b0, 12'h000, 12'h100};
    tbl[15] = '{1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 12'h101};
    tbl[16] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h100, 12'h102};
    tbl[17] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h101, 12'h103};

    repeat (2) @(posedge clock);
    #1;
    check_out("reset", 1'b0, 12'h000, 12'h000);
    reset = 1'b1;

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].ready, tbl[i].rv, tbl[i].rt);
      check_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].pc, tbl[i].addr);
    end

    // PC wrap through 12'hFFF
    step(1'b1, 1'b1, 12'hFFE);
    check_out("wrap_redir", 1'b0, 12'h000, 12'hFFE);
    step(1'b1, 1'b0, 12'h000);
    check_out("wrap_issue", 1'b0, 12'h000, 12'hFFF);
    step(1'b1, 1'b0, 12'h000);
    check_out("wrap_ffe", 1'b1, 12'hFFE, 12'h000);
    step(1'b1, 1'b0, 12'h000);
    check_out("wrap_fff", 1'b1, 12'hFFF, 12'h001);
    step(1'b1, 1'b0, 12'h000);
    check_out("wrap_000", 1'b1, 12'h000, 12'h002);
    step(1'b1, 1'b0, 12'h000);
    check_out("wrap_001", 1'b1, 12'h001, 12'h003);

    // Redirect together with pop of 001 and arrival of 002
    step(1'b1, 1'b1, 12'h200);
    check_out("rpa_redir", 1'b0, 12'h000, 12'h200);
    step(1'b1, 1'b0, 12'h000);
    check_out("rpa_issue", 1'b0, 12'h000, 12'h201);
    step(1'b1, 1'b0, 12'h000);
    check_out("rpa_first", 1'b1, 12'h200, 12'h202);

    // Fill the queue, then reset asynchronously mid-cycle
    step(1'b0, 1'b0, 12'h000);
    check_out("fill", 1'b1, 12'h200, 12'h202);
    #3;
    reset = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 12'h000, 12'h000);
    @(posedge clock);
    #1;
    check_out("rst_hold", 1'b0, 12'h000, 12'h000);
    reset = 1'b1;
    step(1'b1, 1'b0, 12'h000);
    check_out("rst_e0", 1'b0, 12'h000, 12'h001);
    step(1'b1, 1'b0, 12'h000);
    check_out("rst_e1", 1'b1, 12'h000, 12'h002);
    step(1'b1, 1'b0, 12'h000);
    check_out("rst_e2", 1'b1, 12'h001, 12'h003);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
